l1_cache_dm: RTL and testbench



---
 rtl/l1_cache_dm_if.sv | 35 +++
 rtl/l1_cache_dm.sv | 157 +++++++++++++++
 tb/tb_l1_cache_dm.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_cache_dm_if.sv
// ============================================================================
// Module   : l1_cache_dm_if
// Brief    : Processor-port and block-memory-port bundle for l1_cache_dm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l1_cache_dm_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  // Cache side: serves the processor, masters the block memory.
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Environment side: processor requester plus block memory.
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/l1_cache_dm.sv
// ============================================================================
// Module   : l1_cache_dm
// Brief    : Direct-mapped write-back/write-allocate L1 cache, 4-word lines.
//            Optional hit/miss counters enabled by macro L1_CACHE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_cache_dm #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef L1_CACHE_PERF_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  l1_cache_dm_if.slave bus
);

  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [NUM_BLOCKS-1:0] valid, dirty;
  logic [TAG_W-1:0]  line_tag  [NUM_BLOCKS];
  logic [127:0]      line_data [NUM_BLOCKS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [6:0]        word_lsb;
  logic              request, hit, stall;
  logic [31:0]       rdata;

  assign idx      = bus.proc_addr[IDX_W+1:2];
  assign tag      = bus.proc_addr[29:IDX_W+2];
  assign word_lsb = {bus.proc_addr[1:0], 5'd0};
  assign request  = bus.proc_read | bus.proc_write;
  assign hit      = valid[idx] && (line_tag[idx] == tag);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    rdata     = 32'd0;
    case (state)
      IDLE: begin
        if (request && !hit) begin
          stall     = 1'b1;
          state_nxt = dirty[idx] ? WRITEBACK : ALLOCATE;
        end else if (bus.proc_read && hit) begin
          rdata = line_data[idx][word_lsb +: 32];
        end
      end
      WRITEBACK: begin
        stall = 1'b1;
        if (bus.mem_ready) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        stall = 1'b1;
        if (bus.mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gating with rst_n makes an asserted reset release the processor at once.
  assign bus.proc_stall = stall & rst_n;
  assign bus.proc_rdata = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid         <= '0;
      dirty         <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= 28'd0;
      bus.mem_wdata <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.proc_write && hit) begin
            dirty[idx] <= 1'b1;
          end else if (request && !hit) begin
            if (dirty[idx]) begin
              bus.mem_write <= 1'b1;
              bus.mem_addr  <= {line_tag[idx], idx};
              bus.mem_wdata <= line_data[idx];
            end else begin
              bus.mem_read  <= 1'b1;
              bus.mem_addr  <= bus.proc_addr[29:2];
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b1;
            bus.mem_addr  <= bus.proc_addr[29:2];
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            bus.mem_read <= 1'b0;
            valid[idx]   <= 1'b1;
            dirty[idx]   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays need no reset: valid bits qualify every use.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.proc_write && hit) begin
      line_data[idx][word_lsb +: 32] <= bus.proc_wdata;
    end else if (state == ALLOCATE && bus.mem_ready) begin
      line_data[idx] <= bus.mem_rdata;
      line_tag[idx]  <= tag;
    end
  end

`ifdef L1_CACHE_PERF_EN
  logic after_miss;

  // after_miss suppresses counting the re-evaluated hit that ends a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt    <= 32'd0;
      miss_cnt   <= 32'd0;
      after_miss <= 1'b0;
    end else if (state == IDLE && request) begin
      if (hit) begin
        if (after_miss)               after_miss <= 1'b0;
        else if (hit_cnt != '1)       hit_cnt    <= hit_cnt + 32'd1;
      end else begin
        after_miss <= 1'b1;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_cache_dm.sv
// ============================================================================
// Module   : tb_l1_cache_dm
// Brief    : Scoreboard bench for l1_cache_dm with a fixed-latency block memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_cache_dm;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;

  l1_cache_dm_if bus ();

`ifdef L1_CACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  l1_cache_dm #(.NUM_BLOCKS(8), .IDX_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef L1_CACHE_PERF_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [31:0]  exp_rd   [$];
  logic [27:0]  exp_mr   [$];
  logic [27:0]  exp_mw_a [$];
  logic [127:0] exp_mw_d [$];

  logic [127:0] mem [logic [27:0]];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    checks++;
    $display("FAIL %s: DUT produced output with no expected entry", name);
  endtask

  // Block memory: accepts a request, answers LAT cycles later with a one-cycle mem_ready.
  initial begin : g_mem_model
    bit busy;
    int cnt;
    busy = 0;
    cnt  = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 128'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.mem_ready = 1'b0;
        busy = 0;
      end else begin
        if (bus.mem_ready) begin
          bus.mem_ready = 1'b0;
          busy = 0;
        end
        if (!busy && (bus.mem_read || bus.mem_write)) begin
          busy = 1;
          cnt  = 0;
        end else if (busy && !(bus.mem_read || bus.mem_write)) begin
          busy = 0;
        end else if (busy) begin
          cnt++;
          if (cnt == LAT) begin
            bus.mem_ready = 1'b1;
            if (bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 128'd0;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a read result or starts a block transfer.
  initial begin : g_monitor
    logic mr_prev, mw_prev;
    mr_prev = 1'b0;
    mw_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.proc_read && !bus.proc_stall) begin
          if (exp_rd.size() == 0) unexpected("proc_rdata");
          else chk("proc_rdata", 128'(bus.proc_rdata), 128'(exp_rd.pop_front()));
        end
        if (bus.mem_read && !mr_prev) begin
          chk("mem_rw_exclusive", 128'(bus.mem_write), 128'd0);
          if (exp_mr.size() == 0) unexpected("mem_read");
          else chk("mem_read_addr", 128'(bus.mem_addr), 128'(exp_mr.pop_front()));
        end
        if (bus.mem_write && !mw_prev) begin
          chk("mem_rw_exclusive", 128'(bus.mem_read), 128'd0);
          if (exp_mw_a.size() == 0) unexpected("mem_write");
          else begin
            chk("mem_write_addr", 128'(bus.mem_addr), 128'(exp_mw_a.pop_front()));
            chk("mem_wdata", bus.mem_wdata, exp_mw_d.pop_front());
          end
        end
      end
      mr_prev = bus.mem_read;
      mw_prev = bus.mem_write;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] wd, input int exp_stall, input string name);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = wd;
    @(negedge clk);
    while (bus.proc_stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) $display("FAIL %s: request never completed (timeout)", name);
    chk(name, 128'(n), 128'(exp_stall));
    @(posedge clk);
    #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  initial begin : g_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $finish;
  end

  initial begin : g_stim
    int n;
    rst_n          = 1'b0;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = 30'd0;
    bus.proc_wdata = 32'd0;
    mem[28'h4]  = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    mem[28'h44] = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    mem[28'h8]  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    mem[28'h0]  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_stall",     128'(bus.proc_stall), 128'd0);
    chk("reset_mem_read",  128'(bus.mem_read),   128'd0);
    chk("reset_mem_write", 128'(bus.mem_write),  128'd0);
    chk("reset_mem_addr",  128'(bus.mem_addr),   128'd0);
    chk("reset_mem_wdata", bus.mem_wdata,        128'd0);
    chk("reset_rdata",     128'(bus.proc_rdata), 128'd0);

    // Cold read miss, then hit in the same line
    exp_mr.push_back(28'h4);  exp_rd.push_back(32'h1111);
    access(1'b1, 1'b0, 30'h10, 32'd0, 6, "stall_cold_read");
    exp_rd.push_back(32'h4444);
    access(1'b1, 1'b0, 30'h13, 32'd0, 0, "stall_read_hit");

    // Write hit, then dirty eviction by a conflicting read
    access(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, 0, "stall_write_hit");
    exp_mw_a.push_back(28'h4);
    exp_mw_d.push_back({32'h4444, 32'h3333, 32'hDEAD_BEEF, 32'h1111});
    exp_mr.push_back(28'h44);  exp_rd.push_back(32'hB0);
    access(1'b1, 1'b0, 30'h110, 32'd0, 11, "stall_dirty_miss");

    // Write miss allocate, hit on neighbour word, then eviction of the merged line
    exp_mr.push_back(28'h8);
    access(1'b0, 1'b1, 30'h20, 32'hCAFE, 6, "stall_write_miss");
    exp_rd.push_back(32'hC1);
    access(1'b1, 1'b0, 30'h21, 32'd0, 0, "stall_read_hit2");
    exp_mw_a.push_back(28'h8);
    exp_mw_d.push_back({32'hC3, 32'hC2, 32'hC1, 32'hCAFE});
    exp_mr.push_back(28'h0);  exp_rd.push_back(32'hD0);
    access(1'b1, 1'b0, 30'h00, 32'd0, 11, "stall_evict_cafe");

    // Written-back data round trip through memory
    exp_mr.push_back(28'h4);  exp_rd.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 30'h11, 32'd0, 6, "stall_refetch");

    // Reset during a fill
    exp_mr.push_back(28'h2);
    @(posedge clk);
    #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h08;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_read && n < 50);
    chk("fill_started", 128'(bus.mem_read), 128'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_read",  128'(bus.mem_read),   128'd0);
    chk("abort_mem_write", 128'(bus.mem_write),  128'd0);
    chk("abort_stall",     128'(bus.proc_stall), 128'd0);
    bus.proc_read = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    exp_mr.push_back(28'h4);  exp_rd.push_back(32'h1111);
    access(1'b1, 1'b0, 30'h10, 32'd0, 6, "stall_after_reset");
    exp_rd.push_back(32'h1111);
    access(1'b1, 1'b0, 30'h10, 32'd0, 0, "stall_hit_a");
    exp_rd.push_back(32'hDEAD_BEEF);
    access(1'b1, 1'b0, 30'h11, 32'd0, 0, "stall_hit_b");
    exp_rd.push_back(32'h3333);
    access(1'b1, 1'b0, 30'h12, 32'd0, 0, "stall_hit_c");

    repeat (3) @(negedge clk);
`ifdef L1_CACHE_PERF_EN
    chk("miss_cnt", 128'(miss_cnt), 128'd1);
    chk("hit_cnt",  128'(hit_cnt),  128'd3);
`endif
    chk("queues_drained", 128'(exp_rd.size() + exp_mr.size() + exp_mw_a.size()), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
